// File: rtl/comptest_pkg.sv
// Shared types and default sizing for the comparator scan sequencer and its counters.
// Latency: none (types and constants only).
// Backpressure: none.
package comptest_pkg;

    localparam int DAC_WIDTH_DEF    = 12;
    localparam int CNT_WIDTH_DEF    = 16;
    localparam int WDOG_CYCLES_DEF  = 1024;
    localparam int DRAIN_CYCLES_DEF = 3;

    // Scan sequencer states, in the order a normal step walks through them.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_FIRE   = 3'd3,
        ST_WAIT   = 3'd4,
        ST_DRAIN  = 3'd5,
        ST_REPORT = 3'd6,
        ST_STEP   = 3'd7
    } scan_state_e;

endpackage

// File: rtl/scan_step_counter.sv
// Delay (settle/drain), pulse and watchdog counters for one scan step, with terminal-count flags.
// Latency: flags are combinational from the registered counts; counts update one cycle after enable.
// Backpressure: none; the owning FSM holds enables low whenever it is stalled elsewhere.
module scan_step_counter
    import comptest_pkg::*;
#(
    parameter int CNT_WIDTH   = CNT_WIDTH_DEF,
    parameter int WDOG_CYCLES = WDOG_CYCLES_DEF
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 dly_en,
    input  logic [CNT_WIDTH-1:0] dly_target,
    output logic                 dly_tc,
    input  logic                 pulse_clr,
    input  logic                 pulse_inc,
    input  logic [CNT_WIDTH-1:0] pulse_target,
    output logic                 pulse_last,
    input  logic                 wdog_en,
    output logic                 wdog_tc
);

    localparam int                  WDOG_W    = $clog2(WDOG_CYCLES + 1);
    localparam logic [WDOG_W-1:0]   WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);
    localparam logic [CNT_WIDTH:0]  ONE_EXT   = (CNT_WIDTH + 1)'(1);

    logic [CNT_WIDTH-1:0] dly_q, dly_d;
    logic [CNT_WIDTH-1:0] pulse_q, pulse_d;
    logic [WDOG_W-1:0]    wdog_q, wdog_d;

    // The delay counter is free-running while enabled and parked at zero otherwise,
    // so each SETTLE/DRAIN visit starts from a clean count. A target of 0 acts as 1.
    assign dly_tc     = ({1'b0, dly_q} + ONE_EXT) >= {1'b0, dly_target};
    // The pulse now finishing is the last when count+1 reaches the target (0 acts as 1).
    assign pulse_last = ({1'b0, pulse_q} + ONE_EXT) >= {1'b0, pulse_target};
    assign wdog_tc    = wdog_en && (wdog_q == WDOG_LAST);

    // Next-count logic for all three counters.
    always_comb begin
        dly_d   = dly_en ? dly_q + CNT_WIDTH'(1) : '0;
        wdog_d  = wdog_en ? wdog_q + WDOG_W'(1) : '0;
        pulse_d = pulse_q;
        if (pulse_clr) begin
            pulse_d = '0;
        end else if (pulse_inc) begin
            pulse_d = pulse_q + CNT_WIDTH'(1);
        end
    end

    // Counter registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dly_q   <= '0;
            pulse_q <= '0;
            wdog_q  <= '0;
        end else begin
            dly_q   <= dly_d;
            pulse_q <= pulse_d;
            wdog_q  <= wdog_d;
        end
    end

endmodule

// File: rtl/comparator_scan_sequencer.sv
// Sweeps the comparator DAC over a range, fires N injector pulses per setting and reports errors per step.
// Latency: all outputs registered; one result per step after settle + N pulse round trips + drain.
// Backpressure: stalls in REPORT holding result_valid until result_ready; SCAN_EARLY_STOP_EN ends the scan after two error-free steps.
module comparator_scan_sequencer
    import comptest_pkg::*;
#(
    parameter int DAC_WIDTH    = DAC_WIDTH_DEF,
    parameter int CNT_WIDTH    = CNT_WIDTH_DEF,
    parameter int WDOG_CYCLES  = WDOG_CYCLES_DEF,
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [DAC_WIDTH-1:0] dac_start,
    input  logic [DAC_WIDTH-1:0] dac_stop,
    input  logic [DAC_WIDTH-1:0] dac_step,
    input  logic [CNT_WIDTH-1:0] pulses_per_step,
    input  logic [CNT_WIDTH-1:0] settle_cycles,
    output logic [DAC_WIDTH-1:0] dac_value,
    output logic                 dac_load,
    output logic                 fire_pulse,
    input  logic                 pulser_ready,
    input  logic [31:0]          errcnt,
    output logic                 errcnt_rst,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic [DAC_WIDTH-1:0] result_dac,
    output logic [31:0]          result_errcnt,
    output logic                 busy,
    output logic                 done,
    output logic                 aborted,
    output logic                 timeout_err
);

    scan_state_e          state_q, state_d;
    logic [DAC_WIDTH-1:0] dac_value_q, dac_value_d;
    logic [DAC_WIDTH-1:0] result_dac_q, result_dac_d;
    logic [31:0]          result_errcnt_q, result_errcnt_d;
    logic                 dac_load_q, dac_load_d;
    logic                 errcnt_rst_q, errcnt_rst_d;
    logic                 fire_pulse_q, fire_pulse_d;
    logic                 result_valid_q, result_valid_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 aborted_q, aborted_d;
    logic                 timeout_err_q, timeout_err_d;

    logic [DAC_WIDTH-1:0] step_eff;
    logic [DAC_WIDTH:0]   dac_next;
    logic                 range_end;
    logic                 early_stop;

    logic                 dly_en, dly_tc, pulse_clr, pulse_inc, pulse_last, wdog_en, wdog_tc;
    logic [CNT_WIDTH-1:0] dly_target;

    // Next DAC value computed one bit wider so wrapping past full scale is seen as a carry.
    assign step_eff  = (dac_step == '0) ? DAC_WIDTH'(1) : dac_step;
    assign dac_next  = {1'b0, dac_value_q} + {1'b0, step_eff};
    assign range_end = dac_next[DAC_WIDTH] || (dac_next[DAC_WIDTH-1:0] > dac_stop);

`ifdef SCAN_EARLY_STOP_EN
    logic prev_zero_q, prev_zero_d;

    assign early_stop = prev_zero_q && (result_errcnt_q == '0);

    // Remember whether the previously reported step was error-free; a new scan forgets it.
    always_comb begin
        prev_zero_d = prev_zero_q;
        if (state_q == ST_IDLE && start) begin
            prev_zero_d = 1'b0;
        end else if (state_q == ST_STEP) begin
            prev_zero_d = (result_errcnt_q == '0);
        end
    end

    // Early-stop history register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prev_zero_q <= 1'b0;
        end else begin
            prev_zero_q <= prev_zero_d;
        end
    end
`else
    assign early_stop = 1'b0;
`endif

    // Settle and drain share one delay counter; they never overlap.
    assign dly_en     = (state_q == ST_SETTLE) || (state_q == ST_DRAIN);
    assign dly_target = (state_q == ST_DRAIN) ? CNT_WIDTH'(DRAIN_CYCLES) : settle_cycles;
    assign pulse_clr  = (state_q == ST_LOAD);
    assign pulse_inc  = (state_q == ST_DRAIN) && dly_tc;
    assign wdog_en    = (state_q == ST_FIRE) || (state_q == ST_WAIT);

    scan_step_counter #(
        .CNT_WIDTH   (CNT_WIDTH),
        .WDOG_CYCLES (WDOG_CYCLES)
    ) u_step_counter (
        .clock        (clock),
        .reset_n      (reset_n),
        .dly_en       (dly_en),
        .dly_target   (dly_target),
        .dly_tc       (dly_tc),
        .pulse_clr    (pulse_clr),
        .pulse_inc    (pulse_inc),
        .pulse_target (pulses_per_step),
        .pulse_last   (pulse_last),
        .wdog_en      (wdog_en),
        .wdog_tc      (wdog_tc)
    );

    // Next-state and next-output logic; outputs are derived from the next state so they register in step with it.
    always_comb begin
        state_d         = state_q;
        dac_value_d     = dac_value_q;
        result_dac_d    = result_dac_q;
        result_errcnt_d = result_errcnt_q;
        timeout_err_d   = timeout_err_q;
        done_d          = 1'b0;
        aborted_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d       = ST_LOAD;
                    dac_value_d   = dac_start;
                    timeout_err_d = 1'b0;
                end
            end
            ST_LOAD: begin
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (dly_tc) begin
                    state_d = ST_FIRE;
                end
            end
            ST_FIRE: begin
                if (wdog_tc) begin
                    state_d       = ST_REPORT;
                    timeout_err_d = 1'b1;
                end else if (!pulser_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A returning pulser_ready beats a watchdog expiring in the same cycle.
                if (pulser_ready) begin
                    state_d = ST_DRAIN;
                end else if (wdog_tc) begin
                    state_d       = ST_REPORT;
                    timeout_err_d = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (dly_tc) begin
                    state_d = pulse_last ? ST_REPORT : ST_FIRE;
                end
            end
            ST_REPORT: begin
                if (result_valid_q && result_ready) begin
                    state_d = ST_STEP;
                end
            end
            ST_STEP: begin
                if (range_end || early_stop) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d     = ST_LOAD;
                    dac_value_d = dac_next[DAC_WIDTH-1:0];
                end
            end
        endcase

        // Abort wins everywhere but leaves the DAC setting and watchdog flag as they were.
        if (abort) begin
            state_d       = ST_IDLE;
            dac_value_d   = dac_value_q;
            timeout_err_d = timeout_err_q;
            done_d        = 1'b0;
            aborted_d     = (state_q != ST_IDLE);
        end

        // Snapshot the step result on entry to REPORT so it stays stable while stalled.
        if ((state_d == ST_REPORT) && (state_q != ST_REPORT)) begin
            result_dac_d    = dac_value_q;
            result_errcnt_d = errcnt;
        end

        dac_load_d     = (state_d == ST_LOAD);
        errcnt_rst_d   = (state_d == ST_LOAD);
        fire_pulse_d   = (state_d == ST_FIRE);
        result_valid_d = (state_d == ST_REPORT);
        busy_d         = (state_d != ST_IDLE);
    end

    // FSM state and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ST_IDLE;
            dac_value_q     <= '0;
            result_dac_q    <= '0;
            result_errcnt_q <= '0;
            dac_load_q      <= 1'b0;
            errcnt_rst_q    <= 1'b0;
            fire_pulse_q    <= 1'b0;
            result_valid_q  <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            aborted_q       <= 1'b0;
            timeout_err_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            dac_value_q     <= dac_value_d;
            result_dac_q    <= result_dac_d;
            result_errcnt_q <= result_errcnt_d;
            dac_load_q      <= dac_load_d;
            errcnt_rst_q    <= errcnt_rst_d;
            fire_pulse_q    <= fire_pulse_d;
            result_valid_q  <= result_valid_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            aborted_q       <= aborted_d;
            timeout_err_q   <= timeout_err_d;
        end
    end

    assign dac_value     = dac_value_q;
    assign dac_load      = dac_load_q;
    assign errcnt_rst    = errcnt_rst_q;
    assign fire_pulse    = fire_pulse_q;
    assign result_valid  = result_valid_q;
    assign result_dac    = result_dac_q;
    assign result_errcnt = result_errcnt_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign aborted       = aborted_q;
    assign timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_comparator_scan_sequencer.sv
// Scoreboard bench for comparator_scan_sequencer with a behavioural injector and a step-list reference model.
// Latency: n/a.
// Backpressure: result_ready driven always-high, random, or held low per scenario.
module tb_comparator_scan_sequencer;

    typedef struct packed {
        logic [11:0] dac;
        logic [31:0] err;
    } res_t;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic        abort;
    logic [11:0] dac_start;
    logic [11:0] dac_stop;
    logic [11:0] dac_step;
    logic [15:0] pulses_per_step;
    logic [15:0] settle_cycles;
    logic [11:0] dac_value;
    logic        dac_load;
    logic        fire_pulse;
    logic        pulser_ready;
    logic [31:0] errcnt;
    logic        errcnt_rst;
    logic        result_valid;
    logic        result_ready;
    logic [11:0] result_dac;
    logic [31:0] result_errcnt;
    logic        busy;
    logic        done;
    logic        aborted;
    logic        timeout_err;

    int   checks = 0;
    int   errors = 0;
    res_t exp_q[$];

    int done_cnt = 0, abort_cnt = 0, load_seen = 0, rises = 0, rst_seen = 0;
    int inj_base = 0, inj_err_steps = 0;
    bit inj_stuck = 0;
    int ready_mode = 0;

    int exp_steps, exp_rises, exp_to;
    int done_base, rise_base, rst_base, load_base, a_base;
    int cyc, stall_bad, rs, rstp;
    logic [11:0] sd;
    logic [31:0] se;

    comparator_scan_sequencer dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .start           (start),
        .abort           (abort),
        .dac_start       (dac_start),
        .dac_stop        (dac_stop),
        .dac_step        (dac_step),
        .pulses_per_step (pulses_per_step),
        .settle_cycles   (settle_cycles),
        .dac_value       (dac_value),
        .dac_load        (dac_load),
        .fire_pulse      (fire_pulse),
        .pulser_ready    (pulser_ready),
        .errcnt          (errcnt),
        .errcnt_rst      (errcnt_rst),
        .result_valid    (result_valid),
        .result_ready    (result_ready),
        .result_dac      (result_dac),
        .result_errcnt   (result_errcnt),
        .busy            (busy),
        .done            (done),
        .aborted         (aborted),
        .timeout_err     (timeout_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Injector model: busy for 10 cycles per accepted pulse, one error per pulse in the first err_steps steps.
    initial begin : injector
        int  busy_left;
        bit  fire_prev;
        busy_left    = 0;
        fire_prev    = 1'b0;
        pulser_ready = 1'b1;
        errcnt       = '0;
        forever begin
            @(posedge clock);
            #1;
            if (errcnt_rst) begin
                errcnt   = '0;
                rst_seen = rst_seen + 1;
            end
            if (fire_pulse && !fire_prev) begin
                rises = rises + 1;
                if ((rst_seen - inj_base) <= inj_err_steps) errcnt = errcnt + 32'd1;
                if (!inj_stuck && pulser_ready) busy_left = 10;
            end else if (busy_left > 0) begin
                busy_left = busy_left - 1;
            end
            pulser_ready = !inj_stuck && (busy_left == 0);
            fire_prev    = fire_pulse;
        end
    end

    // Consumer ready pattern.
    initial begin : consumer
        result_ready = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            case (ready_mode)
                0:       result_ready = 1'b1;
                1:       result_ready = ($urandom_range(0, 1) == 1);
                default: result_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every accepted result and counts strobes.
    initial begin : monitor
        res_t e;
        forever begin
            @(negedge clock);
            if (done)     done_cnt  = done_cnt + 1;
            if (aborted)  abort_cnt = abort_cnt + 1;
            if (dac_load) load_seen = load_seen + 1;
            if (result_valid && result_ready) begin
                if (exp_q.size() == 0) begin
                    chk("result_unexpected_qsize", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    chk("result_dac", result_dac, e.dac);
                    chk("result_errcnt", result_errcnt, e.err);
                end
            end
        end
    end

    // Reference model: list of step results from the scan rules, using plain arithmetic.
    task automatic model_push(input int s, input int stp, input int st, input int pps,
                              input int err_steps, input bit stuck,
                              output int nsteps, output int nrises);
        int   inc, ppe, v, err;
        bit   fin;
        res_t r;
`ifdef SCAN_EARLY_STOP_EN
        bit   prev_zero;
        prev_zero = 1'b0;
`endif
        inc    = (st == 0) ? 1 : st;
        ppe    = (pps == 0) ? 1 : pps;
        v      = s;
        nsteps = 0;
        nrises = 0;
        fin    = 1'b0;
        while (!fin) begin
            err   = stuck ? 1 : ((nsteps < err_steps) ? ppe : 0);
            r.dac = v[11:0];
            r.err = 32'(err);
            exp_q.push_back(r);
            nrises = nrises + (stuck ? 1 : ppe);
            nsteps = nsteps + 1;
            if ((v + inc > 4095) || (v + inc > stp)) fin = 1'b1;
`ifdef SCAN_EARLY_STOP_EN
            if (prev_zero && err == 0) fin = 1'b1;
            prev_zero = (err == 0);
`endif
            v = v + inc;
        end
    endtask

    task automatic begin_scan(input int s, input int stp, input int st, input int pps,
                              input int settle, input int err_steps, input bit stuck);
        @(posedge clock);
        #1;
        dac_start       = s[11:0];
        dac_stop        = stp[11:0];
        dac_step        = st[11:0];
        pulses_per_step = pps[15:0];
        settle_cycles   = settle[15:0];
        inj_stuck       = stuck;
        inj_err_steps   = err_steps;
        inj_base        = rst_seen;
        rst_base        = rst_seen;
        rise_base       = rises;
        load_base       = load_seen;
        done_base       = done_cnt;
        exp_to          = stuck ? 1 : 0;
        model_push(s, stp, st, pps, err_steps, stuck, exp_steps, exp_rises);
        @(posedge clock);
        #1 start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    task automatic finish_scan(input int budget);
        int c;
        c = 0;
        while (done_cnt == done_base && c < budget) begin
            @(negedge clock);
            c++;
        end
        chk("done_pulses", done_cnt - done_base, 1);
        chk("results_left", exp_q.size(), 0);
        chk("fire_rises", rises - rise_base, exp_rises);
        chk("errcnt_rst_count", rst_seen - rst_base, exp_steps);
        chk("dac_load_count", load_seen - load_base, exp_steps);
        chk("timeout_err", timeout_err, exp_to);
        chk("busy_after_done", busy, 0);
        @(negedge clock);
        chk("done_one_cycle", done, 0);
        exp_q.delete();
    endtask

    initial begin
        reset_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        dac_start = '0;
        dac_stop = '0;
        dac_step = '0;
        pulses_per_step = '0;
        settle_cycles = '0;
        repeat (4) @(posedge clock);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_fire", fire_pulse, 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_dac_value", dac_value, 0);
        chk("rst_flags", {dac_load, errcnt_rst, done, aborted, timeout_err}, 0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("idle_busy", busy, 0);

        // Nominal sweep 100..110 by 5, 4 pulses, with an ignored start mid-scan.
        begin_scan(100, 110, 5, 4, 2, 1000, 0);
        repeat (40) @(posedge clock);
        #1 start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        finish_scan(20000);

        // Consumer stalls for 50 cycles on the first result.
        ready_mode = 2;
        begin_scan(0, 1, 1, 1, 0, 1000, 0);
        cyc = 0;
        while (!result_valid && cyc < 500) begin
            @(negedge clock);
            cyc++;
        end
        chk("stall_valid_seen", result_valid, 1);
        sd = result_dac;
        se = result_errcnt;
        stall_bad = 0;
        repeat (50) begin
            @(negedge clock);
            if (!result_valid || result_dac != sd || result_errcnt != se || fire_pulse) stall_bad++;
        end
        chk("stall_stable", stall_bad, 0);
        chk("stall_dac", sd, 0);
        chk("stall_no_pop", exp_q.size(), 2);
        ready_mode = 0;
        finish_scan(20000);

        // Injector never becomes ready: watchdog per step, scan continues.
        begin_scan(0, 1, 1, 2, 1, 1000, 1);
        cyc = 0;
        while (!fire_pulse && cyc < 200) begin
            @(negedge clock);
            cyc++;
        end
        chk("wdog_fire_seen", fire_pulse, 1);
        cyc = 0;
        while (!timeout_err && cyc < 3000) begin
            @(negedge clock);
            cyc++;
        end
        chk("wdog_cycles", cyc, 1024);
        finish_scan(10000);
        inj_stuck = 0;
        repeat (5) @(posedge clock);

        // Abort while waiting on the injector.
        @(posedge clock);
        #1;
        dac_start = 12'd100;
        dac_stop = 12'd110;
        dac_step = 12'd5;
        pulses_per_step = 16'd4;
        settle_cycles = 16'd2;
        inj_base = rst_seen;
        inj_err_steps = 1000;
        done_base = done_cnt;
        a_base = abort_cnt;
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        cyc = 0;
        while (!fire_pulse && cyc < 200) begin
            @(negedge clock);
            cyc++;
        end
        chk("abort_fire_seen", fire_pulse, 1);
        repeat (3) @(negedge clock);
        @(posedge clock);
        #1 abort = 1'b1;
        @(posedge clock);
        #1 abort = 1'b0;
        chk("abort_fire", fire_pulse, 0);
        chk("abort_busy", busy, 0);
        chk("abort_pulse", aborted, 1);
        chk("abort_dac_hold", dac_value, 100);
        @(posedge clock);
        #1;
        chk("abort_one_cycle", aborted, 0);
        repeat (20) @(posedge clock);
        #1;
        chk("abort_no_done", done_cnt - done_base, 0);
        chk("abort_count", abort_cnt - a_base, 1);

        // Abort while idle produces no pulse.
        a_base = abort_cnt;
        abort = 1'b1;
        @(posedge clock);
        #1 abort = 1'b0;
        chk("idle_abort_pulse", aborted, 0);
        repeat (3) @(posedge clock);
        #1;
        chk("idle_abort_count", abort_cnt - a_base, 0);

        // Top-of-range carry, zero step treated as one, reversed range.
        begin_scan(4094, 4095, 4, 1, 0, 1000, 0);
        finish_scan(20000);
        begin_scan(0, 2, 0, 2, 3, 1000, 0);
        finish_scan(20000);
        begin_scan(20, 10, 1, 1, 0, 1000, 0);
        finish_scan(20000);

        // Errors only in the first step across 0..9.
        begin_scan(0, 9, 1, 1, 0, 1, 0);
        finish_scan(20000);

        // Randomized sweeps with random consumer backpressure.
        ready_mode = 1;
        for (int i = 0; i < 6; i++) begin
            rs = $urandom_range(0, 4095);
            rstp = rs + $urandom_range(0, 10);
            if (rstp > 4095) rstp = 4095;
            begin_scan(rs, rstp, $urandom_range(0, 3), $urandom_range(0, 3),
                       $urandom_range(0, 4), $urandom_range(0, 4), 0);
            finish_scan(20000);
        end
        ready_mode = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
